shift_sequencer: RTL and testbench

Multi-cycle shift engine that applies a single-bit shift or rotate to a 16-bit word a programmed number of times, one step per clock. It sits beside the datapath shift logic in the ALU and issues step operations using the common 3-bit shift-op encoding. It takes a start/busy/done handshake from the ALU control, so shifts by 0..15 positions need no wide barrel shifter.

---
 rtl/shift_sequencer_pkg.sv | 20 ++
 rtl/shift_sequencer_step.sv | 41 ++++
 rtl/shift_sequencer.sv | 106 ++++++++++
 tb/tb_shift_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: shift-op encodings,
// FSM states and default widths.
package shift_sequencer_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned CNT_W_DEF = 4;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_LSL  = 3'b001;
  localparam logic [2:0] OP_LSR  = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seqState_e;

endpackage

// File: rtl/shift_sequencer_step.sv
// Combinational single-step shift/rotate unit using the common 3-bit op code.
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] d,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] q,
  output logic             out_bit
);

  always_comb begin
    q       = d;
    out_bit = 1'b0;
    case (op)
      OP_LSL: begin
        out_bit = d[WIDTH-1];
        q       = {d[WIDTH-2:0], 1'b0};
      end
      OP_LSR: begin
        out_bit = d[0];
        q       = {1'b0, d[WIDTH-1:1]};
      end
      OP_ROL: begin
        out_bit = d[WIDTH-1];
        q       = {d[WIDTH-2:0], d[WIDTH-1]};
      end
      OP_ROR: begin
        out_bit = d[0];
        q       = {d[0], d[WIDTH-1:1]};
      end
      default: begin
        // pass and unassigned encodings leave the word untouched
        q       = d;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift engine: one shift_step per clock, count steps per request,
// with start/busy/done handshake.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dataIn,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] dataOut,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  seqState_e        state;
  seqState_e        nextState;
  logic [2:0]       opReg;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] stepQ;
  logic             stepOut;

  shift_step #(.WIDTH(WIDTH)) uStep (
    .d      (dataOut),
    .op     (opReg),
    .q      (stepQ),
    .out_bit(stepOut)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = (count != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (remaining == CNT_W'(1)) begin
          nextState = DONE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dataOut   <= '0;
      carry     <= 1'b0;
      opReg     <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dataOut   <= dataIn;
            opReg     <= op;
            remaining <= count;
            carry     <= 1'b0;
          end
        end
        SHIFT: begin
          dataOut <= stepQ;
          carry   <= stepOut;
          // SHIFT is only ever entered with remaining >= 1, so this never wraps
          if (remaining != '0) begin
            remaining <= remaining - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: vector table, corner-case
// sequences and randomized requests against an arithmetic reference model.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dataIn;
  logic [2:0]  op;
  logic [3:0]  count;
  logic [15:0] dataOut;
  logic        carry;
  logic        busy;
  logic        done;

  int unsigned errors = 0;
  int unsigned checks = 0;

  shift_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .dataIn (dataIn),
    .op     (op),
    .count  (count),
    .dataOut(dataOut),
    .carry  (carry),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  op;
    logic [3:0]  cnt;
    logic [15:0] expData;
    logic        expCarry;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Whole-operation result computed directly from the shift amount n.
  function automatic void refModel(input logic [15:0] d, input logic [2:0] o, input int unsigned n,
                                   output logic [15:0] r, output logic c);
    int unsigned dv;
    int unsigned rv;
    dv = 32'(d);
    r  = d;
    c  = 1'b0;
    if (n == 0) return;
    case (o)
      3'd1: begin rv = (dv << n) & 32'hFFFF; r = rv[15:0]; c = dv[16-n]; end
      3'd2: begin rv = dv >> n;              r = rv[15:0]; c = dv[n-1]; end
      3'd3: begin rv = ((dv << n) | (dv >> (16 - n))) & 32'hFFFF; r = rv[15:0]; c = rv[0]; end
      3'd4: begin rv = ((dv >> n) | (dv << (16 - n))) & 32'hFFFF; r = rv[15:0]; c = rv[15]; end
      default: begin r = d; c = 1'b0; end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start in cycle 0; expect done exactly in cycle cnt+1 with busy held throughout.
  task automatic runOp(input string name, input logic [15:0] d, input logic [2:0] o,
                       input logic [3:0] cnt, input logic [15:0] expD, input logic expC);
    int unsigned cyc;
    logic busyOk;
    dataIn = d; op = o; count = cnt; start = 1'b1;
    tick();
    start = 1'b0;
    dataIn = 16'($urandom); op = 3'($urandom); count = 4'($urandom);
    cyc = 1;
    busyOk = 1'b1;
    while (!done && cyc < 40) begin
      if (!busy) busyOk = 1'b0;
      tick();
      cyc++;
    end
    chk({name, "_latency"}, cyc, 32'(cnt) + 1);
    chk({name, "_busy"}, {31'd0, busyOk & busy}, 32'd1);
    chk({name, "_data"}, 32'(dataOut), 32'(expD));
    chk({name, "_carry"}, 32'(carry), 32'(expC));
    tick();
    chk({name, "_idle"}, {30'd0, busy, done}, 32'd0);
    chk({name, "_hold"}, {15'd0, carry, dataOut}, {15'd0, expC, expD});
  endtask

  vec_t vecs[$];

  initial begin
    logic [15:0] expD;
    logic        expC;
    logic [15:0] r;
    logic        c;
    int unsigned cyc;
    logic        sawDone;

    rst = 1'b1; start = 1'b0; dataIn = '0; op = '0; count = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_state", {14'd0, busy, done, dataOut}, 32'd0);
    chk("reset_carry", 32'(carry), 32'd0);

    vecs.push_back('{16'h8001, 3'b001, 4'd4,  16'h0010, 1'b0});
    vecs.push_back('{16'h1234, 3'b100, 4'd4,  16'h4123, 1'b0});
    vecs.push_back('{16'hFFFF, 3'b010, 4'd15, 16'h0001, 1'b1});
    vecs.push_back('{16'h0001, 3'b011, 4'd15, 16'h8000, 1'b0});
    vecs.push_back('{16'hA5A5, 3'b001, 4'd0,  16'hA5A5, 1'b0});
    vecs.push_back('{16'hA5A5, 3'b111, 4'd5,  16'hA5A5, 1'b0});
    vecs.push_back('{16'hC003, 3'b000, 4'd3,  16'hC003, 1'b0});
    vecs.push_back('{16'h8000, 3'b001, 4'd1,  16'h0000, 1'b1});
    foreach (vecs[i]) begin
      runOp($sformatf("vec%0d", i), vecs[i].data, vecs[i].op, vecs[i].cnt,
            vecs[i].expData, vecs[i].expCarry);
    end

    // Rotate-right intermediate values, one per cycle.
    dataIn = 16'h1234; op = 3'b100; count = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ror_c1", {15'd0, busy, dataOut}, {15'd0, 1'b1, 16'h1234});
    tick(); chk("ror_c2", 32'(dataOut), 32'h091A);
    tick(); chk("ror_c3", 32'(dataOut), 32'h048D);
    tick(); chk("ror_c4", {15'd0, done, dataOut}, {15'd0, 1'b0, 16'h8246});
    tick(); chk("ror_c5", {15'd0, done, dataOut}, {15'd0, 1'b1, 16'h4123});
    tick();

    // start while busy in cycle 3 and in the DONE cycle 9 is ignored; cycle 10 accepted.
    dataIn = 16'h00F0; op = 3'b011; count = 4'd8; start = 1'b1;
    tick(); start = 1'b0;                                      // cycle 1
    tick();                                                    // cycle 2
    tick(); start = 1'b1; dataIn = 16'hDEAD; op = 3'b001; count = 4'd1;  // cycle 3
    tick(); start = 1'b0;                                      // cycle 4
    repeat (4) tick();                                         // cycle 8
    chk("busy_start_c8", 32'(done), 32'd0);
    tick();                                                    // cycle 9
    refModel(16'h00F0, 3'b011, 8, expD, expC);
    chk("busy_start_done", 32'(done), 32'd1);
    chk("busy_start_data", {15'd0, carry, dataOut}, {15'd0, expC, expD});
    start = 1'b1; dataIn = 16'h0F0F; op = 3'b010; count = 4'd2;
    tick();                                                    // cycle 10
    chk("done_start_ignored", {15'd0, busy, dataOut}, {15'd0, 1'b0, expD});
    tick(); start = 1'b0;                                      // cycle 11
    chk("idle_start_accepted", {15'd0, busy, dataOut}, {15'd0, 1'b1, 16'h0F0F});
    tick(); tick();                                            // cycle 13
    refModel(16'h0F0F, 3'b010, 2, expD, expC);
    chk("second_done", {14'd0, done, carry, dataOut}, {14'd0, 1'b1, expC, expD});
    tick();

    // Reset in cycle 3 of a count=10 operation aborts without a done pulse.
    dataIn = 16'hFFFF; op = 3'b001; count = 4'd10; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick(); rst = 1'b1;                                        // cycle 3
    tick(); rst = 1'b0;                                        // cycle 4
    chk("abort_state", {14'd0, busy, carry, dataOut}, 32'd0);
    sawDone = 1'b0;
    repeat (15) begin
      if (done) sawDone = 1'b1;
      tick();
    end
    chk("abort_no_done", 32'(sawDone), 32'd0);
    runOp("after_abort", 16'h1234, 3'b011, 4'd4, 16'h2341, 1'b1);

    for (int unsigned i = 0; i < 30; i++) begin
      logic [15:0] d;
      logic [2:0]  o;
      logic [3:0]  n;
      d = 16'($urandom);
      o = 3'($urandom_range(0, 7));
      n = 4'($urandom_range(0, 15));
      refModel(d, o, 32'(n), r, c);
      runOp($sformatf("rand%0d", i), d, o, n, r, c);
    end

    cyc = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
